system_pll_reset_ctrl: RTL

PLL reset and lock sequencer sitting directly upstream of the system PLL on the 50 MHz reference clock. It drives the PLL `rst` input, qualifies the PLL `locked` output, and releases the system reset only after lock has been stable for a programmed time. It re-initialises the PLL on lock loss or lock timeout and reports a sticky failure after repeated timeouts.

---
 rtl/system_pll_pkg.sv | 22 ++
 rtl/system_sync2.sv | 27 ++
 rtl/system_pll_reset_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/system_pll_pkg.sv
// Shared types and default timing constants for the system PLL reset/lock sequencer.
//   pll_state_e : sequencer state encoding
//   Def*        : default parameter values for a 50 MHz reference clock
package system_pll_pkg;

  typedef enum logic [2:0] {
    StResetPll,
    StWaitLock,
    StStable,
    StRelease,
    StRun,
    StFail
  } pll_state_e;

  localparam int unsigned DefPllRstCycles = 16;
  localparam int unsigned DefLockTimeout  = 50000;  // 1 ms at 50 MHz
  localparam int unsigned DefStableCycles = 1024;
  localparam int unsigned DefReleaseCycles = 64;
  localparam int unsigned DefLossFilter   = 4;
  localparam int unsigned DefMaxRetries   = 3;

endpackage

// File: rtl/system_sync2.sv
// Two-flop synchronizer for a single asynchronous level signal.
//   clk_i  : destination clock
//   rst_ni : synchronous active-low reset, clears both stages
//   d_i    : asynchronous input
//   q_o    : synchronized output (two cycles of latency)
module system_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/system_pll_reset_ctrl.sv
// PLL reset and lock sequencer on the reference clock. Pulses the PLL reset, waits for a
// qualified lock, holds the system in reset until lock has been stable long enough, and
// re-initialises the PLL on lock loss or lock timeout. Repeated timeouts park it in a
// sticky failure state until software requests a relock or the block is reset.
//   refclk_i      : reference clock (only clock)
//   rst_ni        : synchronous active-low reset
//   locked_i      : PLL lock, asynchronous to refclk_i
//   relock_req_i  : single-cycle request to restart the sequence
//   pll_rst_o     : PLL reset, active high
//   sys_rst_n_o   : system reset, active low
//   pll_ok_o      : high only while running
//   error_o       : high in the failure state
//   loss_count_o  : saturating count of lock-loss events
module system_pll_reset_ctrl
  import system_pll_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = DefPllRstCycles,
  parameter int unsigned LOCK_TIMEOUT   = DefLockTimeout,
  parameter int unsigned STABLE_CYCLES  = DefStableCycles,
  parameter int unsigned RELEASE_CYCLES = DefReleaseCycles,
  parameter int unsigned LOSS_FILTER    = DefLossFilter,
  parameter int unsigned MAX_RETRIES    = DefMaxRetries
) (
  input  logic       refclk_i,
  input  logic       rst_ni,
  input  logic       locked_i,
  input  logic       relock_req_i,
  output logic       pll_rst_o,
  output logic       sys_rst_n_o,
  output logic       pll_ok_o,
  output logic       error_o,
  output logic [7:0] loss_count_o
);

  localparam int unsigned RstW   = $clog2(PLL_RST_CYCLES + 1);
  localparam int unsigned TmrW   = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned StbW   = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned RelW   = $clog2(RELEASE_CYCLES + 1);
  localparam int unsigned FltW   = $clog2(LOSS_FILTER + 1);
  localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);

  // Each counter runs 0..N-1 so its state lasts exactly N cycles.
  localparam logic [RstW-1:0]   RstLast  = RstW'(PLL_RST_CYCLES - 1);
  localparam logic [TmrW-1:0]   TmrLast  = TmrW'(LOCK_TIMEOUT - 1);
  localparam logic [StbW-1:0]   StbLast  = StbW'(STABLE_CYCLES - 1);
  localparam logic [RelW-1:0]   RelLast  = RelW'(RELEASE_CYCLES - 1);
  localparam logic [FltW-1:0]   FltLast  = FltW'(LOSS_FILTER - 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRIES);

  pll_state_e        state_q, state_d;
  logic [RstW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [TmrW-1:0]   tmr_q, tmr_d;
  logic [StbW-1:0]   stb_cnt_q, stb_cnt_d;
  logic [RelW-1:0]   rel_cnt_q, rel_cnt_d;
  logic [FltW-1:0]   flt_q, flt_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [7:0]        loss_q, loss_d;
  logic              pll_rst_q, sys_rst_n_q, pll_ok_q, error_q;
  logic              locked_s;

  system_sync2 u_lock_sync (
    .clk_i  (refclk_i),
    .rst_ni (rst_ni),
    .d_i    (locked_i),
    .q_o    (locked_s)
  );

  // Per-state counters default to zero, so each one is cleared whenever its state is left
  // and starts from zero on the next entry.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = '0;
    tmr_d     = '0;
    stb_cnt_d = '0;
    rel_cnt_d = '0;
    flt_d     = '0;
    retry_d   = retry_q;
    loss_d    = loss_q;
    if (relock_req_i) begin
      state_d = StResetPll;
      retry_d = '0;
    end else begin
      unique case (state_q)
        StResetPll: begin
          if (rst_cnt_q == RstLast) state_d = StWaitLock;
          else rst_cnt_d = rst_cnt_q + 1'b1;
        end
        StWaitLock: begin
          if (locked_s) begin
            state_d = StStable;
          end else if (tmr_q == TmrLast) begin
            retry_d = retry_q + 1'b1;
            state_d = (retry_d == RetryMax) ? StFail : StResetPll;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        StStable: begin
          if (!locked_s) state_d = StWaitLock;
          else if (stb_cnt_q == StbLast) state_d = StRelease;
          else stb_cnt_d = stb_cnt_q + 1'b1;
        end
        StRelease: begin
          if (!locked_s) begin
            state_d = StResetPll;
          end else if (rel_cnt_q == RelLast) begin
            state_d = StRun;
            retry_d = '0;
          end else begin
            rel_cnt_d = rel_cnt_q + 1'b1;
          end
        end
        StRun: begin
          // Short low glitches on lock are filtered; any high cycle restarts the filter.
          if (!locked_s) begin
            if (flt_q == FltLast) begin
              state_d = StResetPll;
              if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
            end else begin
              flt_d = flt_q + 1'b1;
            end
          end
        end
        StFail: ;
        default: state_d = StResetPll;
      endcase
    end
  end

  // Outputs decode the next state so they move on the same edge as the state register.
  always_ff @(posedge refclk_i) begin
    if (!rst_ni) begin
      state_q     <= StResetPll;
      rst_cnt_q   <= '0;
      tmr_q       <= '0;
      stb_cnt_q   <= '0;
      rel_cnt_q   <= '0;
      flt_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      pll_ok_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      tmr_q       <= tmr_d;
      stb_cnt_q   <= stb_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      flt_q       <= flt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_rst_q   <= (state_d == StResetPll) || (state_d == StFail);
      sys_rst_n_q <= (state_d == StRun);
      pll_ok_q    <= (state_d == StRun);
      error_q     <= (state_d == StFail);
    end
  end

  assign pll_rst_o    = pll_rst_q;
  assign sys_rst_n_o  = sys_rst_n_q;
  assign pll_ok_o     = pll_ok_q;
  assign error_o      = error_q;
  assign loss_count_o = loss_q;

endmodule
